// File: rtl/byang_inv_sched.sv
// byang_inv_sched: round-robin scheduler sharing one byang_inv among
// NUM_REQ requesters. Define BYANG_SCHED_STATS_EN for issue/stall counters.
module byang_inv_sched #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_DEPTH  = 4,
  parameter int PRIME_BITS = 256,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PW = $clog2(TAG_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef BYANG_SCHED_STATS_EN
  output logic [15:0]                   stat_issued,
  output logic [15:0]                   stat_stall,
`endif
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*PRIME_BITS-1:0] req_a,
  output logic                          inv_valid_in,
  input  logic                          inv_ready_in,
  output logic [PRIME_BITS-1:0]         inv_a,
  input  logic                          inv_valid_out,
  output logic                          inv_ready_out,
  input  logic [PRIME_BITS-1:0]         inv_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IW-1:0]                 rsp_id,
  output logic [PRIME_BITS-1:0]         rsp_result
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_hold;
  logic [IW-1:0] r_tags [TAG_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic          w_found;
  logic [IW-1:0] w_srch;
  logic [IW:0]   w_sum;
  logic          w_gnt_v;
  logic [IW-1:0] w_gnt;
  logic          w_full;
  logic          w_empty;
  logic          w_issue;
  logic          w_pop;

  // Round-robin search: lowest offset from r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_srch  = '0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ))
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (req_valid[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_srch  = w_sum[IW-1:0];
      end
    end
  end

  // A stalled grant is pinned in HOLD until it issues.
  assign w_gnt_v = (r_state == HOLD) | w_found;
  assign w_gnt   = (r_state == HOLD) ? r_hold : w_srch;
  assign w_full  = (r_count == CW'(TAG_DEPTH));
  assign w_empty = (r_count == '0);

  assign inv_valid_in  = rst_n & w_gnt_v & ~w_full;
  assign inv_a         = req_a[int'(w_gnt)*PRIME_BITS +: PRIME_BITS];
  assign w_issue       = inv_valid_in & inv_ready_in;
  assign req_ready     = w_issue ? (NUM_REQ'(1) << w_gnt) : '0;

  assign rsp_valid     = rst_n & inv_valid_out & ~w_empty;
  assign inv_ready_out = rst_n & rsp_ready & ~w_empty;
  assign rsp_id        = r_tags[r_rd];
  assign rsp_result    = inv_result;
  assign w_pop         = rsp_valid & rsp_ready;

  // Arbiter next-state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB:     if (inv_valid_in && !inv_ready_in) w_state_nxt = HOLD;
      HOLD:    if (w_issue) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // Arbiter state, round-robin pointer and latched grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_hold   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && w_state_nxt == HOLD)
        r_hold <= w_gnt;
      if (w_issue)
        r_rr_ptr <= (w_gnt == IW'(NUM_REQ - 1)) ? '0 : w_gnt + IW'(1);
    end
  end

  // Tag storage; validity is tracked by the pointers only.
  always_ff @(posedge clk) begin
    if (w_issue)
      r_tags[r_wr] <= w_gnt;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_issue) r_wr <= r_wr + PW'(1);
      if (w_pop)   r_rd <= r_rd + PW'(1);
      if (w_issue && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_issue && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

`ifdef BYANG_SCHED_STATS_EN
  logic [15:0] r_issued;
  logic [15:0] r_stall;

  // Saturating issue and stall counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issued <= '0;
      r_stall  <= '0;
    end else begin
      if (w_issue && r_issued != 16'hFFFF)
        r_issued <= r_issued + 16'd1;
      if (w_gnt_v && !w_issue && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign stat_issued = r_issued;
  assign stat_stall  = r_stall;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/byang_inv_sched.md
BYANG_INV_SCHED -- requirements
Module: byang_inv_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one byang_inv instance (range 2..8).
REQ-002 Parameter TAG_DEPTH, default 4, in-flight tag FIFO depth (power of two, at least 4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 req_ready  output  NUM_REQ  per-requester operand accepted.
REQ-007 req_a  input  NUM_REQ*PRIME_BITS  operands; requester i occupies slice i; held stable while req_valid[i] is high.
REQ-008 inv_valid_in / inv_ready_in / inv_a  output / input / output  1 / 1 / PRIME_BITS  issue port to byang_inv valid_in/ready_in/a_in.
REQ-009 inv_valid_out / inv_ready_out / inv_result  input / output / input  1 / 1 / PRIME_BITS  return port from byang_inv valid_out/ready_out/result.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-011 rsp_id  output  clog2(NUM_REQ)  index of the requester owning rsp_result.
REQ-012 rsp_result  output  PRIME_BITS  inverse mod SECP256K1_P, equal to inv_result.

Function
REQ-013 Arbiter FSM states: ARB and HOLD; reset state ARB.
REQ-014 ARB: grant the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ; combinational grant.
REQ-015 inv_valid_in is high only when a grant exists and tag FIFO count < TAG_DEPTH; inv_a = req_a slice of grant.
REQ-016 req_ready[g] = inv_valid_in & inv_ready_in for granted g; all other bits low; at most one bit high per cycle.
REQ-017 Issue handshake (inv_valid_in & inv_ready_in): push g into tag FIFO, rr_ptr <= (g+1) mod NUM_REQ, FSM stays or returns to ARB.
REQ-018 inv_valid_in high with inv_ready_in low: FSM -> HOLD, granted index latched; HOLD keeps grant and inv_a stable until the handshake, then -> ARB; higher-priority arrivals do not preempt.
REQ-019 Issue blocked while FIFO count == TAG_DEPTH, regardless of a same-cycle pop; in HOLD the grant is kept and inv_valid_in is held low.
REQ-020 rsp_valid = inv_valid_out & FIFO non-empty; rsp_id = FIFO head; rsp_result = inv_result; inv_ready_out = rsp_ready & FIFO non-empty.
REQ-021 Response handshake pops FIFO head; simultaneous push and pop leave count unchanged and preserve order.
REQ-022 Scheduler adds zero cycles of latency on issue and return paths; the only registered state is the FSM, rr_ptr, latched grant, FIFO, and stats.
REQ-023 Responses return in issue order; FIFO pointers wrap modulo TAG_DEPTH.

Reset
REQ-024 On rst_n low at clk edge: FSM=ARB, rr_ptr=0, FIFO empty (count=0), stats cleared.
REQ-025 During and after reset, until new requests arrive: req_ready=0, inv_valid_in=0, rsp_valid=0, inv_ready_out=0.
REQ-026 In-flight tags are discarded on reset; byang_inv shares rst_n, so no orphan results occur.

Configuration
REQ-027 With BYANG_SCHED_STATS_EN defined: adds outputs stat_issued[15:0] (issue handshakes) and stat_stall[15:0] (cycles with a grant but no issue); both saturating at 0xFFFF and cleared by reset.
REQ-028 Without BYANG_SCHED_STATS_EN: stat ports and counters are absent; all other behaviour is identical.

Verification
REQ-029 Requester 0 sends a=1, rsp_ready=1 -> one response, rsp_id=0, rsp_result=1.
REQ-030 Requester 2 sends a=2 -> rsp_id=2, rsp_result=(p+1)/2=0x7FFF...FFFF7FFFFE18.
REQ-031 All 4 requesters are valid at the same cycle with operands 3,5,7,11 -> issue order 0,1,2,3; responses in that order with correct ids; product of each result with its operand mod p is 1.
REQ-032 rsp_ready is held low while 4 requesters are valid -> at most TAG_DEPTH issues, then inv_valid_in stays low; after rsp_ready rises, all 4 complete in order.
REQ-033 inv_ready_in is forced low with requester 1 valid, then requester 0 becomes valid -> grant stays 1 (HOLD), inv_a stable; requester 1 is issued first.
REQ-034 rst_n is pulsed low for one cycle mid-computation -> all outputs low the next cycle, FIFO empty; a fresh request a=1 returns 1.
